// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioning front end: channel indices,
// the idle (released) level and the default debounce window.
package button_conditioner_pkg;

  localparam int unsigned BTN_HL = 0;
  localparam int unsigned BTN_HR = 1;
  localparam int unsigned BTN_VU = 2;
  localparam int unsigned BTN_VD = 3;

  localparam logic BTN_RELEASED = 1'b1;

  localparam int unsigned NUM_BUTTONS_DEFAULT     = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;  // 10 ms at 50 MHz

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, persistence counter, debounced
// active-low level and single-cycle press/release pulses.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic level_next_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s1_q, s2_q;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch can be inferred.
  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_d     = cnt_q;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // The new level has persisted for the full window: accept it.
      level_d   = s2_q;
      cnt_d     = '0;
      press_d   = ~s2_q;
      release_d = s2_q;
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: non-blocking assignments here so every flop samples the values from
  // before the edge; blocking would collapse the synchroniser into one stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= BTN_RELEASED;
      s2_q      <= BTN_RELEASED;
      level_q   <= BTN_RELEASED;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level_o      = level_q;
  assign level_next_o = level_d;
  assign press_o      = press_q;
  assign release_o    = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BUTTONS raw active-low buttons into clean levels, edge pulses
// and a registered "any button held" flag aligned with the level change.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = NUM_BUTTONS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic                   any_pressed
);

  logic [NUM_BUTTONS-1:0] level_next;
  logic                   any_pressed_q;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_i       (btn_raw[i]),
      .level_o     (btn_level[i]),
      .level_next_o(level_next[i]),
      .press_o     (btn_press[i]),
      .release_o   (btn_release[i])
    );
  end

  // Built from next-state levels so the flag moves on the same edge as btn_level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_pressed_q <= 1'b0;
    end else begin
      any_pressed_q <= ~&level_next;
    end
  end

  assign any_pressed = any_pressed_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with an 8-cycle debounce window.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned DB = 8;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          any_pressed;

  int errors = 0;
  int checks = 0;

  button_conditioner #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_pressed(any_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed state packed as {level, press, release, any_pressed}.
  function automatic logic [12:0] st(input logic [3:0] l, input logic [3:0] p,
                                     input logic [3:0] r, input logic a);
    return {l, p, r, a};
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got lvl=%b prs=%b rel=%b any=%b, expected lvl=%b prs=%b rel=%b any=%b",
               tag, got[12:9], got[8:5], got[4:1], got[0],
               exp[12:9], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  function automatic logic [12:0] obs();
    return {btn_level, btn_press, btn_release, any_pressed};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply a steady raw value and expect the level to move on exactly edge 10.
  task automatic transition(input string tag, input logic [3:0] raw,
                            input logic [3:0] old_l, input logic [3:0] new_l,
                            input logic [3:0] p, input logic [3:0] r);
    btn_raw = raw;
    for (int e = 1; e <= DB + 1; e++) begin
      step();
      check({tag, "_wait"}, obs(), st(old_l, 4'b0, 4'b0, ~&old_l));
    end
    step();
    check({tag, "_edge"}, obs(), st(new_l, p, r, ~&new_l));
    step();
    check({tag, "_after"}, obs(), st(new_l, 4'b0, 4'b0, ~&new_l));
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 4'b0000;

    // Reset holds everything idle even with all buttons pressed.
    for (int c = 0; c < 3; c++) begin
      step();
      check("reset_hold", obs(), st(4'hF, 4'h0, 4'h0, 1'b0));
    end
    rst_n = 1'b1;
    transition("rst_release", 4'b0000, 4'hF, 4'h0, 4'hF, 4'h0);
    transition("all_up", 4'b1111, 4'h0, 4'hF, 4'h0, 4'hF);

    // Clean press and release of hl.
    transition("hl_press", 4'b1110, 4'hF, 4'hE, 4'h1, 4'h0);
    transition("hl_release", 4'b1111, 4'hE, 4'hF, 4'h0, 4'h1);

    // hr bounces with a 3-cycle half period, then settles pressed.
    for (int i = 0; i < 40; i++) begin
      btn_raw = {2'b11, ((i / 3) % 2 == 1), 1'b1};
      step();
      check("hr_bounce", obs(), st(4'hF, 4'h0, 4'h0, 1'b0));
    end
    transition("hr_settle", 4'b1101, 4'hF, 4'hD, 4'h2, 4'h0);
    transition("hr_release", 4'b1111, 4'hD, 4'hF, 4'h0, 4'h2);

    // vu glitch one cycle short of the window is rejected.
    btn_raw = 4'b1011;
    for (int c = 0; c < 7; c++) begin
      step();
      check("vu_glitch7", obs(), st(4'hF, 4'h0, 4'h0, 1'b0));
    end
    btn_raw = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      step();
      check("vu_glitch7_after", obs(), st(4'hF, 4'h0, 4'h0, 1'b0));
    end

    // An 8-cycle hold is exactly long enough.
    btn_raw = 4'b1011;
    for (int c = 0; c < 8; c++) begin
      step();
      check("vu_hold8", obs(), st(4'hF, 4'h0, 4'h0, 1'b0));
    end
    btn_raw = 4'b1111;
    step();
    check("vu_hold8_e9", obs(), st(4'hF, 4'h0, 4'h0, 1'b0));
    step();
    check("vu_hold8_accept", obs(), st(4'hB, 4'h4, 4'h0, 1'b1));
    for (int e = 11; e <= 17; e++) begin
      step();
      check("vu_hold8_low", obs(), st(4'hB, 4'h0, 4'h0, 1'b1));
    end
    step();
    check("vu_hold8_release", obs(), st(4'hF, 4'h0, 4'h4, 1'b0));
    step();
    check("vu_hold8_idle", obs(), st(4'hF, 4'h0, 4'h0, 1'b0));

    // hl and hr together, then hr released on its own.
    transition("hl_hr_press", 4'b1100, 4'hF, 4'hC, 4'h3, 4'h0);
    transition("hr_only_release", 4'b1110, 4'hC, 4'hE, 4'h0, 4'h2);
    transition("hl_release2", 4'b1111, 4'hE, 4'hF, 4'h0, 4'h1);

    // Reset while vd's count is at 5 discards the partial count.
    btn_raw = 4'b0111;
    for (int c = 0; c < 7; c++) begin
      step();
      check("vd_count", obs(), st(4'hF, 4'h0, 4'h0, 1'b0));
    end
    rst_n = 1'b0;
    step();
    check("vd_mid_reset", obs(), st(4'hF, 4'h0, 4'h0, 1'b0));
    rst_n = 1'b1;
    transition("vd_after_reset", 4'b0111, 4'hF, 4'h7, 4'h8, 4'h0);
    transition("vd_release", 4'b1111, 4'h7, 4'hF, 4'h0, 4'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream stage for the player movement controllers.
- Takes raw, asynchronous, bouncing active-low board push-buttons and synchronises each one to clk.
- Debounces each button and drives clean active-low levels that feed the controllers' hl/hr/vu/vd button inputs directly.
- Also produces single-cycle press and release pulses for game logic such as start, pause and throw.

Parameters:
- NUM_BUTTONS, 4, number of independent button channels (bit 0 hl, 1 hr, 2 vu, 3 vd).
- DEBOUNCE_CYCLES, 'd500000, consecutive cycles a new synchronised level must persist before it is accepted (10 ms at 50 MHz). Legal range is 1 to 2^24-1.
- Derived localparam CNT_WIDTH = $clog2(DEBOUNCE_CYCLES+1). This is not overridable.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- btn_raw  input  NUM_BUTTONS  raw board buttons, asynchronous, active-low (0 = pressed).
- btn_level  output  NUM_BUTTONS  debounced level, active-low (0 = pressed), registered.
- btn_press  output  NUM_BUTTONS  one-cycle high pulse when btn_level goes 1->0, registered.
- btn_release  output  NUM_BUTTONS  one-cycle high pulse when btn_level goes 0->1, registered.
- any_pressed  output  1  high when any btn_level bit is 0, registered.

Behaviour:
- Reset (rst_n == 0 at a rising edge):
  - sync stages all 1.
  - btn_level all 1 (released).
  - counters 0.
  - btn_press/btn_release 0.
  - any_pressed 0.
  - Reset wins over every other event. A bounce in progress is discarded, with no pulse.
- Synchroniser: two-flop chain per channel, s1 <= btn_raw[i], s2 <= s1. Only s2 is used downstream.
- Debounce, per channel, each edge out of reset:
  - If s2 == btn_level[i]: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: btn_level[i] <= s2 and counter <= 0. Pulse btn_press[i] (if s2 == 0) or btn_release[i] (if s2 == 1) for exactly this one cycle.
  - Else: counter <= counter + 1.
- Level updates therefore happen after DEBOUNCE_CYCLES consecutive edges with s2 != btn_level[i]. Any glitch back to the stable level restarts the count from 0.
- Latency: a raw change held steadily updates btn_level DEBOUNCE_CYCLES+2 edges after the first sampling edge (2 sync + DEBOUNCE_CYCLES). Pulses align with the btn_level change.
- Pulses are otherwise 0. Press and release never assert together on one channel. Different channels may pulse in the same cycle.
- any_pressed is registered from the next-state btn_level, so it changes on the same edge as btn_level.
- Channels are fully independent. A simultaneous press of hl and hr yields both levels 0; resolving that conflict is the consumer's job.
- Counter saturation is impossible, because it is cleared at DEBOUNCE_CYCLES-1. Width CNT_WIDTH has no wrap.
- DEBOUNCE_CYCLES == 1: the level follows s2 one edge late, with pulses still generated.
- Raw held constant at the reset value (all 1) produces no activity after reset release.

Decomposition:
- Shared header (game_defines.vh):
  - Button index constants BTN_HL=0, BTN_HR=1, BTN_VU=2, BTN_VD=3.
  - BTN_RELEASED=1'b1.
  - Default DEBOUNCE_CYCLES.
- One sub-module, debounce_channel: synchroniser, counter, level and the two pulses for one bit. Ports clk, rst_n, raw, level, press, release.
- Top-level button_conditioner instantiates NUM_BUTTONS copies in a generate loop and adds the any_pressed OR-reduction register.

Test Plan (DEBOUNCE_CYCLES=8, NUM_BUTTONS=4):
- Reset: hold rst_n=0 3 cycles with btn_raw=4'b0000 -> btn_level=4'b1111, press/release=0, any_pressed=0 throughout; after release btn_level[0] falls exactly 10 edges after first sampling edge.
- Clean press: btn_raw[0] 1->0 held -> btn_level[0]=0 on edge 10, btn_press[0]=1 for that one cycle only, any_pressed=1 same edge; release 0->1 -> btn_release[0] one cycle at edge 10 later.
- Bounce: btn_raw[1] toggles 0/1 every 3 cycles for 40 cycles then settles 0 -> no level change or pulse during toggling; btn_level[1]=0 exactly 10 edges after final settle.
- Short glitch: btn_raw[2]=0 for 7 cycles then back to 1 -> btn_level[2] stays 1, no pulses; 8-cycle (post-sync) hold -> accepted.
- Simultaneous: btn_raw[0] and btn_raw[1] fall on same edge -> both levels 0 and both press pulses on the same cycle; independent release of bit 1 leaves bit 0 untouched.
- Reset mid-bounce: btn_raw[3]=0 held, assert rst_n=0 at count 5 for 1 cycle -> no pulse, counter restarts; btn_level[3]=0 10 edges after reset release.
